// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key decoder:
//   - ps2_state_e     : frame receiver states
//   - PS2_EXT_PREFIX  : extended-key prefix byte (0xE0)
//   - PS2_BRK_PREFIX  : break (key release) prefix byte (0xF0)
//   - CODE_W          : width of one decoded code entry {break, extended, code}
//   - odd_parity_ok() : true when a data byte plus its parity bit has odd parity
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         CODE_W         = 10;

  // PS/2 uses odd parity over the 8 data bits and the parity bit.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Read side of the decoded-code queue.
//   code_data  : head entry {break, extended, code[7:0]}
//   code_valid : queue holds at least one entry
//   code_read  : pop request, honoured only while code_valid is high
// Modports:
//   master : queue side (drives data/valid, receives read)
//   slave  : consumer side (receives data/valid, drives read)
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;

  logic [ps2_pkg::CODE_W-1:0] code_data;
  logic                       code_valid;
  logic                       code_read;

  modport master (
    output code_data,
    output code_valid,
    input  code_read
  );

  modport slave (
    input  code_data,
    input  code_valid,
    output code_read
  );

endinterface

// File: rtl/ps2_code_fifo.sv
// ---------------------------------------------------------------------------
// ps2_code_fifo
// Synchronous FIFO for decoded key codes with a registered head output.
// Parameters:
//   DEPTH : number of entries (power of two, >= 2)
//   WIDTH : entry width
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write request for push_data
//   push_data  : entry to enqueue
//   overflow   : sticky, set when a push was dropped because the FIFO was full
//   rd         : read-side bus (head data, non-empty flag, pop request)
// Occupancy is tracked with one extra pointer bit instead of a counter:
// equal pointers mean empty, MSBs differing with equal low bits mean full.
// ---------------------------------------------------------------------------
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CODE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  output logic                 overflow,
  ps2_key_decoder_if.master    rd
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic full;
  logic pop;
  logic push_ok;

  always_comb begin
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop     = rd.code_read && valid_q;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds then.
    push_ok = push && (!full || pop);

    wptr_d  = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    valid_d = (wptr_d != rptr_d);
    ovf_d   = ovf_q || (push && full && !pop);

    // Next head: if the slot becoming the head is the one written this
    // cycle, bypass the memory and take the incoming entry directly.
    head_d = '0;
    if (valid_d) begin
      if (push_ok && (rptr_d == wptr_q)) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      head_q  <= head_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage carries no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= push_data;
    end
  end

  assign rd.code_data  = head_q;
  assign rd.code_valid = valid_q;
  assign overflow      = ovf_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Receives PS/2 keyboard frames, decodes E0/F0 prefixes, queues the decoded
// codes and tracks the held state of a configurable set of keys.
// Parameters:
//   FIFO_DEPTH     : decoded-code queue depth (power of two, >= 2)
//   NUM_KEYS       : number of tracked keys (1..16)
//   TIMEOUT_CYCLES : Clock_50 cycles without a PS/2 clock edge before a
//                    partial frame is abandoned
// Ports:
//   Clock_50, Reset : system clock, asynchronous active-high reset
//   PS2_clock/data  : raw PS/2 lines (asynchronous)
//   Key_table       : entry i = bits [9i+8:9i] = {extended, scan code}
//   Code_read       : pop request for the code queue
//   Code_data       : queue head {break, extended, code[7:0]}
//   Code_valid      : queue non-empty
//   Key_pressed     : held state of each Key_table entry
//   Parity_error    : one-cycle pulse on bad parity
//   Frame_error     : one-cycle pulse on bad stop bit or watchdog timeout
//   Overflow        : sticky, a code was dropped because the queue was full
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int NUM_KEYS       = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  Clock_50,
  input  logic                  Reset,
  input  logic                  PS2_clock,
  input  logic                  PS2_data,
  input  logic [NUM_KEYS*9-1:0] Key_table,
  input  logic                  Code_read,
  output logic [CODE_W-1:0]     Code_data,
  output logic                  Code_valid,
  output logic [NUM_KEYS-1:0]   Key_pressed,
  output logic                  Parity_error,
  output logic                  Frame_error,
  output logic                  Overflow
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronizers and edge detection
  logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
  logic ps2d_s1_q, ps2d_s2_q;
  logic ps2c_fall;
  logic ps2c_any_edge;

  // Frame receiver state
  ps2_state_e           state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 ext_q, ext_d;
  logic                 brk_q, brk_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [NUM_KEYS-1:0]  key_q, key_d;

  logic                 timeout;
  logic                 code_push;
  logic [CODE_W-1:0]    code_push_data;
  logic                 fifo_overflow;

  ps2_key_decoder_if code_bus ();

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      ps2c_s1_q   <= 1'b0;
      ps2c_s2_q   <= 1'b0;
      ps2c_prev_q <= 1'b0;
      ps2d_s1_q   <= 1'b0;
      ps2d_s2_q   <= 1'b0;
    end else begin
      ps2c_s1_q   <= PS2_clock;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= PS2_data;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign ps2c_fall     = !ps2c_s2_q && ps2c_prev_q;
  assign ps2c_any_edge = ps2c_s2_q ^ ps2c_prev_q;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    parity_d       = parity_q;
    ext_d          = ext_q;
    brk_d          = brk_q;
    perr_d         = 1'b0;
    ferr_d         = 1'b0;
    key_d          = key_q;
    code_push      = 1'b0;
    code_push_data = {brk_q, ext_q, shift_q};

    // Watchdog restarts on any PS/2 clock activity and is idle between frames.
    wd_cnt_d = (state_q == ST_IDLE || ps2c_any_edge) ? '0 : wd_cnt_q + 1'b1;
    timeout  = (state_q != ST_IDLE) && !ps2c_any_edge &&
               (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));

    if (timeout) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (ps2c_fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ps2d_s2_q) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_d   = {ps2d_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = ps2d_s2_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          // A bad stop bit takes precedence over a parity failure.
          if (!ps2d_s2_q) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (!odd_parity_ok({parity_q, shift_q})) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (shift_q == PS2_EXT_PREFIX) begin
            ext_d = 1'b1;
          end else if (shift_q == PS2_BRK_PREFIX) begin
            brk_d = 1'b1;
          end else begin
            code_push = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
            // Key state follows every decoded code, even one the queue drops.
            for (int i = 0; i < NUM_KEYS; i++) begin
              if (Key_table[9*i +: 9] == {ext_q, shift_q}) begin
                key_d[i] = !brk_q;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      wd_cnt_q  <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      wd_cnt_q  <= wd_cnt_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      key_q     <= key_d;
    end
  end

  ps2_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (Clock_50),
    .rst       (Reset),
    .push      (code_push),
    .push_data (code_push_data),
    .overflow  (fifo_overflow),
    .rd        (code_bus.master)
  );

  assign code_bus.code_read = Code_read;
  assign Code_data          = code_bus.code_data;
  assign Code_valid         = code_bus.code_valid;
  assign Key_pressed        = key_q;
  assign Parity_error       = perr_q;
  assign Frame_error        = ferr_q;
  assign Overflow           = fifo_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder. PS/2 frames are bit-banged at a slow
// rate relative to Clock_50; all driving and sampling happens on the falling
// edge of Clock_50. Key table: entry0=01C, entry1=175, entry2=075, entry3=01C.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int FIFO_DEPTH = 8;
  localparam int NUM_KEYS   = 4;
  localparam int TO_CYCLES  = 200;

  logic                  clk;
  logic                  Reset;
  logic                  PS2_clock;
  logic                  PS2_data;
  logic [NUM_KEYS*9-1:0] Key_table;
  logic [NUM_KEYS-1:0]   Key_pressed;
  logic                  Parity_error;
  logic                  Frame_error;
  logic                  Overflow;

  ps2_key_decoder_if rd_bus ();

  int n_cmp  = 0;
  int n_fail = 0;
  int perr_seen = 0;
  int ferr_seen = 0;

  ps2_key_decoder #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .NUM_KEYS       (NUM_KEYS),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .Clock_50     (clk),
    .Reset        (Reset),
    .PS2_clock    (PS2_clock),
    .PS2_data     (PS2_data),
    .Key_table    (Key_table),
    .Code_read    (rd_bus.code_read),
    .Code_data    (rd_bus.code_data),
    .Code_valid   (rd_bus.code_valid),
    .Key_pressed  (Key_pressed),
    .Parity_error (Parity_error),
    .Frame_error  (Frame_error),
    .Overflow     (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high samples of the error pulses (= pulse width in cycles).
  always @(negedge clk) begin
    if (Parity_error) perr_seen++;
    if (Frame_error)  ferr_seen++;
  end

  // One PS/2 bit: data set while clock high, falling edge mid-bit.
  // With pop_here, Code_read is pulsed in exactly the cycle the falling
  // edge reaches the receiver (2 sync flops + 1 edge-detect stage).
  task automatic ps2_bit(input logic v, input bit pop_here);
    PS2_data = v;
    repeat (3) @(negedge clk);
    PS2_clock = 1'b0;
    if (pop_here) begin
      repeat (2) @(negedge clk);
      rd_bus.code_read = 1'b1;
      @(negedge clk);
      rd_bus.code_read = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    PS2_clock = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input bit stop_bit, input bit pop_at_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ flip_par, 1'b0);
    ps2_bit(stop_bit, pop_at_stop);
    PS2_data = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_pop();
    rd_bus.code_read = 1'b1;
    @(negedge clk);
    rd_bus.code_read = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    PS2_clock = 1'b1;
    PS2_data = 1'b1;
    rd_bus.code_read = 1'b0;
    Key_table = {9'h01C, 9'h075, 9'h175, 9'h01C};
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rd_bus.code_valid); end
    n_cmp++; if (rd_bus.code_data !== 10'h000) begin n_fail++; $display("FAIL reset_data got %h want 000", rd_bus.code_data); end
    n_cmp++; if (Key_pressed !== 4'b0000) begin n_fail++; $display("FAIL reset_keys got %b want 0000", Key_pressed); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", Parity_error); end
    n_cmp++; if (Frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", Frame_error); end
    n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", Overflow); end
    Reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_make();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (rd_bus.code_valid !== 1'b1) begin n_fail++; $display("FAIL make_valid got %b want 1", rd_bus.code_valid); end
    n_cmp++; if (rd_bus.code_data !== 10'h01C) begin n_fail++; $display("FAIL make_data got %h want 01C", rd_bus.code_data); end
    n_cmp++; if (Key_pressed !== 4'b1001) begin n_fail++; $display("FAIL make_keys got %b want 1001", Key_pressed); end
    do_pop();
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL make_pop_valid got %b want 0", rd_bus.code_valid); end
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL brk_prefix_valid got %b want 0", rd_bus.code_valid); end
    n_cmp++; if (Key_pressed !== 4'b1001) begin n_fail++; $display("FAIL brk_prefix_keys got %b want 1001", Key_pressed); end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (rd_bus.code_data !== 10'h21C) begin n_fail++; $display("FAIL brk_data got %h want 21C", rd_bus.code_data); end
    n_cmp++; if (Key_pressed !== 4'b0000) begin n_fail++; $display("FAIL brk_keys got %b want 0000", Key_pressed); end
    do_pop();
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL brk_single_entry got %b want 0", rd_bus.code_valid); end
  endtask

  task automatic test_ext_break();
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (Key_pressed !== 4'b0110) begin n_fail++; $display("FAIL ext_make_keys got %b want 0110", Key_pressed); end
    n_cmp++; if (rd_bus.code_data !== 10'h075) begin n_fail++; $display("FAIL ext_first got %h want 075", rd_bus.code_data); end
    do_pop();
    n_cmp++; if (rd_bus.code_data !== 10'h175) begin n_fail++; $display("FAIL ext_second got %h want 175", rd_bus.code_data); end
    do_pop();
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (rd_bus.code_data !== 10'h375) begin n_fail++; $display("FAIL ext_brk_data got %h want 375", rd_bus.code_data); end
    n_cmp++; if (Key_pressed !== 4'b0100) begin n_fail++; $display("FAIL ext_brk_keys got %b want 0100", Key_pressed); end
    do_pop();
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL ext_brk_single got %b want 0", rd_bus.code_valid); end
  endtask

  task automatic test_errors();
    int p0, f0;
    p0 = perr_seen; f0 = ferr_seen;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (perr_seen - p0 !== 1) begin n_fail++; $display("FAIL par_pulse got %0d want 1", perr_seen - p0); end
    n_cmp++; if (ferr_seen - f0 !== 0) begin n_fail++; $display("FAIL par_no_ferr got %0d want 0", ferr_seen - f0); end
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL par_no_push got %b want 0", rd_bus.code_valid); end
    n_cmp++; if (Key_pressed !== 4'b0100) begin n_fail++; $display("FAIL par_keys got %b want 0100", Key_pressed); end
    p0 = perr_seen; f0 = ferr_seen;
    send_frame(8'h1B, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ferr_seen - f0 !== 1) begin n_fail++; $display("FAIL stop_pulse got %0d want 1", ferr_seen - f0); end
    n_cmp++; if (perr_seen - p0 !== 0) begin n_fail++; $display("FAIL stop_no_perr got %0d want 0", perr_seen - p0); end
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL stop_no_push got %b want 0", rd_bus.code_valid); end
    p0 = perr_seen; f0 = ferr_seen;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (ferr_seen - f0 !== 1) begin n_fail++; $display("FAIL both_ferr got %0d want 1", ferr_seen - f0); end
    n_cmp++; if (perr_seen - p0 !== 0) begin n_fail++; $display("FAIL both_no_perr got %0d want 0", perr_seen - p0); end
    // A parity failure must clear a pending break prefix.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (rd_bus.code_data !== 10'h01C) begin n_fail++; $display("FAIL prefix_cleared got %h want 01C", rd_bus.code_data); end
    n_cmp++; if (Key_pressed !== 4'b1101) begin n_fail++; $display("FAIL prefix_cleared_keys got %b want 1101", Key_pressed); end
    do_pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
    n_cmp++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", Overflow); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rd_bus.code_data !== 10'h010 + 10'(i)) begin n_fail++; $display("FAIL ovf_order[%0d] got %h want %h", i, rd_bus.code_data, 10'h010 + 10'(i)); end
      do_pop();
    end
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b want 0", rd_bus.code_valid); end
    n_cmp++; if (Key_pressed !== 4'b1101) begin n_fail++; $display("FAIL ovf_keys got %b want 1101", Key_pressed); end
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset got %b want 0", Overflow); end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b1, 1'b0);
    send_frame(8'h28, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pop_push got %b want 0", Overflow); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rd_bus.code_data !== 10'h021 + 10'(i)) begin n_fail++; $display("FAIL pp_order[%0d] got %h want %h", i, rd_bus.code_data, 10'h021 + 10'(i)); end
      do_pop();
    end
    n_cmp++; if (rd_bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL pp_drained got %b want 0", rd_bus.code_valid); end
  endtask

  task automatic test_timeout();
    int cnt;
    bit seen;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    // 4th data bit by hand so the idle count starts at the last clock edge.
    PS2_data = 1'b1;
    repeat (3) @(negedge clk);
    PS2_clock = 1'b0;
    repeat (6) @(negedge clk);
    PS2_clock = 1'b1;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (Frame_error) seen = 1'b1;
    end
    // 2 sync flops + 1 edge stage + TIMEOUT_CYCLES count + 1 output register.
    n_cmp++; if (!seen || cnt != TO_CYCLES + 4) begin n_fail++; $display("FAIL timeout_time got %0d want %0d", cnt, TO_CYCLES + 4); end
    @(negedge clk);
    n_cmp++; if (Frame_error !== 1'b0) begin n_fail++; $display("FAIL timeout_width got %b want 0", Frame_error); end
    PS2_data = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (rd_bus.code_data !== 10'h01C) begin n_fail++; $display("FAIL timeout_recover got %h want 01C", rd_bus.code_data); end
    n_cmp++; if (Key_pressed !== 4'b1001) begin n_fail++; $display("FAIL timeout_keys got %b want 1001", Key_pressed); end
    do_pop();
  endtask

  task automatic test_midframe_reset();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b1 == 1'b0);
    ps2_bit(1'b1, 1'b0);
    Reset = 1'b1;
    PS2_data = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (Key_pressed !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_keys got %b want 0000", Key_pressed); end
    Reset = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (rd_bus.code_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid got %b want 1", rd_bus.code_valid); end
    n_cmp++; if (rd_bus.code_data !== 10'h01C) begin n_fail++; $display("FAIL mid_data got %h want 01C", rd_bus.code_data); end
    do_pop();
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_ext_break();
    test_errors();
    test_overflow();
    test_timeout();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
